arrow_input_queue: RTL

//  Input-side companion to the snake game core. Conditions the four raw arrow buttons
//  (synchronise, debounce, press-edge detect) and filters illegal turns. Queues legal

---
 rtl/snake_pkg.sv | 29 ++
 rtl/button_debouncer.sv | 55 +++++
 rtl/arrow_input_queue.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: direction encoding, reset heading,
// turn request payload and the reversal helper.
package snake_pkg;

  localparam int unsigned DIR_W   = 2;
  localparam int unsigned SEED_W  = 26;
  localparam int unsigned NUM_BTN = 4;

  typedef enum logic [DIR_W-1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam dir_t RESET_HEADING = DIR_DOWN;

  // Winning press of a cycle after priority selection.
  typedef struct packed {
    logic valid;
    dir_t dir;
  } turn_req_t;

  // Up/down and left/right differ only in bit 0.
  function automatic dir_t dir_opposite(input dir_t d);
    return dir_t'(d ^ DIR_W'(1));
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Conditions one raw button: 2-FF synchroniser, polarity normalisation,
// stable-count debounce and a single-cycle press pulse on a 0->1 level change.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   raw        : raw button, asynchronous to clk
//   level      : debounced pressed state (active-high)
//   press      : 1-cycle pulse when level rises
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 200_000,
  parameter logic        ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             pressed_c;

  assign pressed_c = sync2 ^ ACTIVE_LOW;

  // Synchroniser resets to the idle raw level so reset never looks like a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (pressed_c != level) begin
        if (cnt == CNT_MAX) begin
          level <= pressed_c;
          press <= pressed_c;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/arrow_input_queue.sv
// Arrow-button front end for the snake core: debounces four buttons, picks one
// press per cycle, rejects same-direction and reversal turns, queues legal
// turns for the game tick and mixes press timing into an apple-placement seed.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   arrow_up/down/left/right : raw buttons
//   dir, dir_valid       : queue head (or current heading when empty), queue non-empty
//   dir_ready            : game tick consumes the head
//   overflow             : 1-cycle pulse when a legal turn is dropped on a full queue
//   seed                 : entropy word
//   btn_level            : debounced pressed state {right, left, down, up}
module arrow_input_queue
  import snake_pkg::*;
#(
  parameter int unsigned          DEBOUNCE_CYCLES = 200_000,
  parameter int unsigned          QUEUE_DEPTH     = 2,
  parameter logic [NUM_BTN-1:0]   ACTIVE_LOW_MASK = 4'b0011
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arrow_up,
  input  logic               arrow_down,
  input  logic               arrow_left,
  input  logic               arrow_right,
  output logic [DIR_W-1:0]   dir,
  output logic               dir_valid,
  input  logic               dir_ready,
  output logic               overflow,
  output logic [SEED_W-1:0]  seed,
  output logic [NUM_BTN-1:0] btn_level
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] press;
  turn_req_t          req_c;

  dir_t              mem   [QUEUE_DEPTH];
  dir_t              mem_n [QUEUE_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_n;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0]  tail_ptr_c;
  logic [CNT_W-1:0]  count, count_n;
  dir_t              heading, heading_n;
  dir_t              ref_c;
  dir_t              dir_n;
  logic              legal_c, pop_c, push_c, ovf_c;
  logic [SEED_W-1:0] ctr;
  logic [SEED_W-1:0] mixed_c, seed_n;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign raw = {arrow_right, arrow_left, arrow_down, arrow_up};

  // One conditioner per button.
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW_MASK[g])
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[g]),
      .level (btn_level[g]),
      .press (press[g])
    );
  end

  // Priority select: lowest index (up) wins, others are discarded.
  always_comb begin
    req_c = '{valid: 1'b0, dir: DIR_UP};
    for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
      if (press[i]) begin
        req_c.valid = 1'b1;
        req_c.dir   = dir_t'(DIR_W'(i));
      end
    end
  end

  assign tail_ptr_c = (wr_ptr == '0) ? PTR_W'(QUEUE_DEPTH - 1) : wr_ptr - PTR_W'(1);

  // Turn filter, FIFO next state and seed mixing.
  always_comb begin
    mem_n     = mem;
    rd_ptr_n  = rd_ptr;
    wr_ptr_n  = wr_ptr;
    heading_n = heading;
    seed_n    = seed;
    mixed_c   = seed ^ ctr;

    pop_c   = (count != '0) && dir_ready;
    // Filter against the newest pending turn so queued double-taps chain correctly.
    ref_c   = (count != '0) ? mem[tail_ptr_c] : heading;
    legal_c = req_c.valid && (req_c.dir != ref_c) && (req_c.dir != dir_opposite(ref_c));
    // A same-cycle pop frees the slot before the push.
    push_c  = legal_c && ((count != CNT_W'(QUEUE_DEPTH)) || pop_c);
    ovf_c   = legal_c && !push_c;

    if (pop_c) begin
      heading_n = mem[rd_ptr];
      rd_ptr_n  = ptr_inc(rd_ptr);
    end
    if (push_c) begin
      mem_n[wr_ptr] = req_c.dir;
      wr_ptr_n      = ptr_inc(wr_ptr);
    end
    count_n = count + CNT_W'(push_c) - CNT_W'(pop_c);
    dir_n   = (count_n != '0) ? mem_n[rd_ptr_n] : heading_n;

    // Every press, legal or not, contributes timing entropy; zero is not a usable seed.
    if (|press) begin
      seed_n = (mixed_c == '0) ? SEED_W'(1) : mixed_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem[i] <= DIR_UP;
      end
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      heading   <= RESET_HEADING;
      dir       <= RESET_HEADING;
      dir_valid <= 1'b0;
      overflow  <= 1'b0;
      seed      <= SEED_W'(1);
      ctr       <= '0;
    end else begin
      mem       <= mem_n;
      rd_ptr    <= rd_ptr_n;
      wr_ptr    <= wr_ptr_n;
      count     <= count_n;
      heading   <= heading_n;
      dir       <= dir_n;
      dir_valid <= (count_n != '0);
      overflow  <= ovf_c;
      seed      <= seed_n;
      ctr       <= ctr + SEED_W'(1);
    end
  end

endmodule
